// File: rtl/cdb_round_robin_arbiter_pkg.sv
// cdb_pkg: shared definitions for the common-data-bus arbiter and the issue
// arbiters that reuse rr_picker.
//   - default parameter values for the CDB datapath
//   - CDB channel index constants (branch unit is channel 0)
//   - cdbEntry_t: result/ROB/control triple at the default widths
//   - idx_bits(): width of a binary index into n channels (at least 1)
package cdb_pkg;

  localparam int unsigned CDB_WIDTH_DEF       = 31;
  localparam int unsigned CDB_ROB_DEF         = 2;
  localparam int unsigned CDB_CONTROL_DEF     = 6;
  localparam int unsigned CDB_CHANNELS_DEF    = 4;
  localparam bit          CDB_PRIORITY_EN_DEF = 1'b1;
  localparam int unsigned CDB_MAX_CHANNELS    = 8;

  typedef enum logic [2:0] {
    CH_BRANCH = 3'd0,
    CH_ALU    = 3'd1,
    CH_LSU    = 3'd2,
    CH_MUL    = 3'd3
  } cdbChannel_t;

  typedef struct packed {
    logic [CDB_WIDTH_DEF:0]   result;
    logic [CDB_ROB_DEF:0]     rob;
    logic [CDB_CONTROL_DEF:0] control;
  } cdbEntry_t;

  function automatic int unsigned idx_bits(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_round_robin_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker with optional absolute
// priority for the branch channel (index 0).
// Ports:
//   occ          in  N   requesters currently holding work
//   pointer      in  IW  first index searched by the round-robin scan
//   grant        out N   one-hot grant (all zero when nothing is occupied)
//   index        out IW  binary index of the granted channel
//   valid        out 1   a grant was issued
//   priority_hit out 1   grant came from the fixed-priority path; the
//                        caller leaves its pointer alone in that case
module rr_picker
  import cdb_pkg::*;
#(
  parameter int unsigned N           = CDB_CHANNELS_DEF,
  parameter bit          PRIORITY_EN = CDB_PRIORITY_EN_DEF,
  localparam int unsigned IW         = idx_bits(N)
) (
  input  logic [N-1:0]  occ,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid,
  output logic          priority_hit
);

  localparam int unsigned PRIO_CH = int'(CH_BRANCH);

  always_comb begin
    int unsigned cand;
    cand         = 0;
    grant        = '0;
    index        = '0;
    valid        = 1'b0;
    priority_hit = 1'b0;
    if (PRIORITY_EN && occ[PRIO_CH]) begin
      grant[PRIO_CH] = 1'b1;
      index          = IW'(PRIO_CH);
      valid          = 1'b1;
      priority_hit   = 1'b1;
    end else begin
      // Scan N slots starting at pointer, wrapping; first occupied wins.
      for (int unsigned k = 0; k < N; k++) begin
        cand = (32'(pointer) + k) % N;
        if (!valid && occ[cand]) begin
          grant[cand] = 1'b1;
          index       = IW'(cand);
          valid       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_round_robin_arbiter.sv
// cdb_round_robin_arbiter: N-channel common-data-bus arbiter. Each functional
// unit hands its result to a one-entry holding buffer and moves on; buffered
// results are broadcast one per cycle on a registered CDB, round-robin, with
// optional absolute priority for the branch unit (channel 0).
// Ports:
//   clk        in   rising-edge clock
//   clearN     in   asynchronous active-low reset
//   flush      in   synchronous squash of buffered and outgoing results
//   request    in   [CHANNELS]             per-channel result valid
//   result     in   [CHANNELS*(WIDTH+1)]   per-channel result, packed
//   robEntry   in   [CHANNELS*(ROB+1)]     per-channel ROB tag, packed
//   controlPC  in   [CHANNELS*(CONTROL+1)] per-channel control tag, packed
//   available  out  [CHANNELS]  channel may present a request this cycle
//   busValid   out  one-cycle CDB broadcast strobe
//   busResult  out  broadcast result (holds when busValid=0)
//   busRob     out  broadcast ROB tag
//   busControl out  broadcast control tag
//   busSource  out  index of the channel that won the broadcast
module cdb_round_robin_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned WIDTH       = CDB_WIDTH_DEF,
  parameter int unsigned ROB         = CDB_ROB_DEF,
  parameter int unsigned CONTROL     = CDB_CONTROL_DEF,
  parameter int unsigned CHANNELS    = CDB_CHANNELS_DEF,
  parameter bit          PRIORITY_EN = CDB_PRIORITY_EN_DEF
) (
  input  logic                              clk,
  input  logic                              clearN,
  input  logic                              flush,
  input  logic [CHANNELS-1:0]               request,
  input  logic [CHANNELS*(WIDTH+1)-1:0]     result,
  input  logic [CHANNELS*(ROB+1)-1:0]       robEntry,
  input  logic [CHANNELS*(CONTROL+1)-1:0]   controlPC,
  output logic [CHANNELS-1:0]               available,
  output logic                              busValid,
  output logic [WIDTH:0]                    busResult,
  output logic [ROB:0]                      busRob,
  output logic [CONTROL:0]                  busControl,
  output logic [$clog2(CHANNELS)-1:0]       busSource
);

  localparam int unsigned IW = idx_bits(CHANNELS);

  // Same layout as cdbEntry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH:0]   result;
    logic [ROB:0]     rob;
    logic [CONTROL:0] control;
  } entry_t;

  logic [CHANNELS-1:0] occ;
  entry_t              entry_q  [CHANNELS];
  entry_t              incoming [CHANNELS];
  entry_t              granted;
  logic [IW-1:0]       pointer;
  logic [IW-1:0]       next_pointer;
  logic [CHANNELS-1:0] grant;
  logic [IW-1:0]       grant_index;
  logic                grant_valid;
  logic                priority_hit;
  logic [CHANNELS-1:0] capture;

  rr_picker #(
    .N           (CHANNELS),
    .PRIORITY_EN (PRIORITY_EN)
  ) u_picker (
    .occ          (occ),
    .pointer      (pointer),
    .grant        (grant),
    .index        (grant_index),
    .valid        (grant_valid),
    .priority_hit (priority_hit)
  );

  // A slot being drained this cycle can accept a new result at the same edge.
  assign available = ~occ | grant;
  assign capture   = request & available;

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      incoming[i].result  = result[i*(WIDTH+1) +: (WIDTH+1)];
      incoming[i].rob     = robEntry[i*(ROB+1) +: (ROB+1)];
      incoming[i].control = controlPC[i*(CONTROL+1) +: (CONTROL+1)];
    end
  end

  // One-hot mux keeps the select in range for non-power-of-two CHANNELS.
  always_comb begin
    granted = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) granted = entry_q[i];
    end
  end

  assign next_pointer = (grant_index == IW'(CHANNELS - 1)) ? '0 : grant_index + IW'(1);

  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      occ        <= '0;
      pointer    <= '0;
      busValid   <= 1'b0;
      busResult  <= '0;
      busRob     <= '0;
      busControl <= '0;
      busSource  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) entry_q[i] <= '0;
    end else if (flush) begin
      // Squash everything in flight; pointer and bus data fields are kept.
      occ      <= '0;
      busValid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (capture[i]) begin
          occ[i]     <= 1'b1;
          entry_q[i] <= incoming[i];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
      busValid <= grant_valid;
      if (grant_valid) begin
        busResult  <= granted.result;
        busRob     <= granted.rob;
        busControl <= granted.control;
        busSource  <= grant_index;
        if (!priority_hit) pointer <= next_pointer;
      end
    end
  end

endmodule

// File: doc/cdb_round_robin_arbiter.md
# cdb_round_robin_arbiter

Parametrised N-channel common-data-bus arbiter with per-channel one-entry holding buffers, round-robin fairness, optional fixed-priority channel and flush. It sits between the functional units (ALU, branch, load/store, ...) and the registered CDB broadcast that feeds the reservation stations and ROB. It generalises the two-channel ALU/branch arbiter to CHANNELS units. Units hand off results through a valid/available handshake and move on without stalling on bus contention.

## Interface
- WIDTH, 31, result MSB index (result is WIDTH+1 bits)
- ROB, 2, ROB index MSB (robEntry is ROB+1 bits)
- CONTROL, 6, control/PC-tag MSB (CONTROL+1 bits)
- CHANNELS, 4, number of requesting units (2..8)
- PRIORITY_EN, 1, when 1 channel 0 (branch unit) has absolute priority

Ports:
- clk  in  1  clock, rising edge
- clearN  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all pending and outgoing results
- request  in  CHANNELS  per-channel result valid
- result  in  CHANNELS×(WIDTH+1)  per-channel result, packed
- robEntry  in  CHANNELS×(ROB+1)  per-channel ROB tag
- controlPC  in  CHANNELS×(CONTROL+1)  per-channel control tag
- available  out  CHANNELS  channel may present a request this cycle
- busValid  out  1  CDB broadcast valid
- busResult  out  WIDTH+1  broadcast result
- busRob  out  ROB+1  broadcast ROB tag
- busControl  out  CONTROL+1  broadcast control tag
- busSource  out  $clog2(CHANNELS)  index of winning channel

## Operation
- Per channel: holding register {occ, result, rob, control}.
- available[i] = ~occ[i] | grant[i] (combinational). Capture at edge when request[i] & available[i].
- request[i] while available[i]=0 is ignored; the unit holds and retries.
- Arbitration (combinational over occ): if PRIORITY_EN and occ[0], grant channel 0. Else grant the first occupied channel searching from pointer upward, wrapping modulo CHANNELS.
- Pointer: after a round-robin grant to i, pointer = (i+1) mod CHANNELS. Unchanged on a priority grant or on no grant.
- Granted entry is copied to the bus registers at the edge. Its occ clears unless refilled at the same edge.
- busValid=1 for exactly one cycle per grant. Bus data fields hold their last value when busValid=0.
- flush at an edge: all occ←0, busValid←0, that edge's captures and grant discarded, pointer unchanged.
- Reset: all occ=0, pointer=0, busValid=0, busResult/busRob/busControl/busSource=0. available is all 1 during and after reset.

## Timing
- Request captured at edge k. Earliest broadcast is registered at edge k+1 (busValid high during cycle k+1..k+2). Minimum latency is 1 cycle after capture.
- Throughput: one broadcast per cycle. Each channel sustains one result per cycle only while it wins.
- Same-edge grant and refill of a channel is legal. The new entry is eligible from the following cycle.
- Worst-case wait for a non-priority occupied channel with PRIORITY_EN=0: CHANNELS−1 cycles. With PRIORITY_EN=1, channel 0 can starve the others; this is accepted, since the branch unit never issues back-to-back.
- Reset mid-operation discards pending entries asynchronously. No broadcast occurs for them.

## Structure
- Shared package cdb_pkg: cdbEntry_t struct {result, rob, control}, CDB channel index constants (CH_BRANCH=0, CH_ALU=1, ...), parameter defaults.
- One sub-module, rr_picker: combinational, takes occ, pointer and PRIORITY_EN, and returns a one-hot grant plus a binary index. It is reused by the issue arbiters.
- Top holds the holding registers, pointer and bus registers.

## Test plan
- Single request: ch1 request=1, result=60, rob=1 at edge k -> busValid=1, busResult=60, busRob=1, busSource=1 after edge k+1; available[1]=1 throughout.
- All four channels request at the same edge, PRIORITY_EN=0, pointer=0 -> broadcasts in source order 0,1,2,3 on consecutive cycles; available low for pending channels until granted.
- PRIORITY_EN=1 with ch0 and ch2 occupied, pointer=2 -> ch0 broadcasts first, then ch2; pointer stays 2 after the ch0 grant and becomes 3 after the ch2 grant.
- Back-to-back ch1 alone: request every cycle with results 5,6,7 -> busResult 5,6,7 on consecutive cycles; available[1] stays 1.
- flush asserted with ch1 and ch3 occupied and busValid=1 -> next cycle busValid=0, both occ clear, available all 1; no stale broadcast afterwards.
- clearN pulsed low mid-stream -> all outputs 0 and available all 1 immediately; the first post-reset request broadcasts normally with pointer starting at 0.
